// File: rtl/sr_alu_arb_pkg.sv
// sr_alu_arb_pkg: ALU opcodes and arbiter FSM states shared by the ALU-sharing slice.
package sr_alu_arb_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_EXEC = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;
endpackage

// File: rtl/sr_alu.sv
// sr_alu: combinational ALU shared by the requesters; undefined opcodes fall back to ADD.
module sr_alu
    import sr_alu_arb_pkg::*;
(
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  oper,
    output logic        zero,
    output logic [31:0] result
);
    always_comb begin
        case (oper)
            ALU_OR:   result = srcA | srcB;
            ALU_SRL:  result = srcA >> srcB[4:0];
            ALU_SLTU: result = {31'b0, srcA < srcB};
            ALU_SUB:  result = srcA - srcB;
            ALU_SLL:  result = srcA << srcB[4:0];
            ALU_AND:  result = srcA & srcB;
            ALU_XOR:  result = srcA ^ srcB;
            ALU_SRA:  result = $signed(srcA) >>> srcB[4:0];
            ALU_SLT:  result = {31'b0, $signed(srcA) < $signed(srcB)};
            default:  result = srcA + srcB;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

// File: rtl/sr_rr_arbiter.sv
// sr_rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
module sr_rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o
);
    // Scan from farthest to nearest so the request closest to ptr_i is written last and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en_i && req_i[(int'(ptr_i) + k) % N]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = IDW'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/sr_alu_arb.sv
// sr_alu_arb: round-robin sharing of one combinational ALU among N_REQ requesters,
// one operation in flight, IDLE -> EXEC -> RESP.
module sr_alu_arb
    import sr_alu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ*4-1:0]    req_oper,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic [31:0]           alu_srcA,
    output logic [31:0]           alu_srcB,
    output logic [3:0]            alu_oper,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero
);
    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d, id_q, id_d, gnt_idx;
    logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic [N_REQ-1:0] gnt;
    logic             rsp_hs;

    // Gating with rst_n keeps req_ready low while reset is held.
    sr_rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .en_i  (rst_n && state_q == ARB_IDLE),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign req_ready  = gnt;
    assign rsp_hs     = (state_q == ARB_RESP) && rsp_ready[id_q];
    assign rsp_valid  = (state_q == ARB_RESP) ? N_REQ'(1) << id_q : '0;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign alu_srcA   = a_q;
    assign alu_srcB   = b_q;
    assign alu_oper   = op_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        if (|gnt) begin
            state_d = ARB_EXEC;
            id_d    = gnt_idx;
            rr_d    = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            a_d     = req_a[32 * int'(gnt_idx) +: 32];
            b_d     = req_b[32 * int'(gnt_idx) +: 32];
            op_d    = req_oper[4 * int'(gnt_idx) +: 4];
        end else if (state_q == ARB_EXEC) begin
            state_d = ARB_RESP;
            res_d   = alu_result;
            zero_d  = alu_zero;
        end else if (rsp_hs) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
endmodule
